writeback_unit: RTL and testbench
=================================

# writeback_unit

Drives the register file's single write port (write_en, write_reg, write_value) from the two result producers in the datapath: the single-cycle ALU and the multi-cycle data-memory load path. Completed results enter an in-order FIFO, and the head entry is written to the register file one per cycle. A scoreboard mask of registers with pending writes is exported so decode can stall on RAW hazards against in-flight results.

## Interface
- DEPTH, 4, FIFO entries (≥2)
- DATA_W, 8, result width (matches register width)

- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_reg  in  2  ALU destination register (0-3)
- alu_value  in  DATA_W  ALU result
- ld_issue  in  1  load issued this cycle; reserves its destination
- ld_reg  in  2  load destination register
- ld_done  in  1  load data returns this cycle (cannot be held off)
- ld_value  in  DATA_W  load data
- write_en  out  1  to register file write_en
- write_reg  out  2  to register file write_reg
- write_value  out  DATA_W  to register file write_value
- busy_mask  out  4  bit i = register i has a pending write
- stall  out  1  producers must not present alu_valid or ld_issue
- ld_busy  out  1  a load is outstanding
- proto_err  out  1  sticky protocol-violation flag

## Operation
- State: FIFO of {reg, value}, count (0..DEPTH), load-outstanding flag plus its reg, proto_err.
- Enqueue order within a cycle: the ld_done entry (older) goes first, then alu_valid. Up to 2 enqueues per cycle.
- Dequeue: when count>0, the head drives write_en=1 with write_reg and write_value, and the head pops at cycle end. When empty: write_en=0, write_reg=0, write_value=0.
- stall = (count ≥ DEPTH-1), a combinational function of registered count. This guarantees no overflow: when stall is high only ld_done can enqueue, and a pop happens the same cycle.
- alu_valid while stall: entry dropped, proto_err set.
- ld_issue accepted when !ld_busy, or when ld_done is high the same cycle (back-to-back loads). Otherwise it is ignored and proto_err is set. ld_issue while stall is also ignored and sets proto_err.
- ld_done while no load is outstanding: ignored, proto_err set. An ld_done entry takes its reg from the stored load reg.
- ld_busy = load-outstanding flag (registered). It sets on an accepted ld_issue and clears on ld_done without a same-cycle ld_issue.
- busy_mask = OR over valid FIFO entries' regs, OR the outstanding load reg. It is combinational from registered state, so inputs in cycle N are reflected in cycle N+1.
- Multiple pending writes to the same reg are legal. They are written in order, and the last one wins. The busy bit stays set until the last of them is written.
- reset: FIFO emptied, load flag cleared, proto_err cleared. In-flight results are discarded; a later ld_done is then a protocol error.

## Timing
- Reset values: write_en=0, write_reg=0, write_value=0, busy_mask=0, stall=0, ld_busy=0, proto_err=0.
- Latency: a result presented in cycle N gives write_en high in cycle N+1 (empty FIFO). The register file captures it at the end of N+1.
- Throughput: 1 write per cycle. The queue grows only when ld_done and alu_valid coincide.
- Simultaneous enqueue(s) and dequeue in one cycle: count' = count + enq − deq.
- FIFO pointers wrap modulo DEPTH. count width is clog2(DEPTH+1).
- proto_err stays high until reset.

## Test plan
- Single ALU: alu_valid, reg 2, value 0x5A in cycle 0 -> cycle 1 shows write_en=1, reg 2, 0x5A, and busy_mask=0100 -> cycle 2 shows write_en=0 and busy_mask=0.
- Load: ld_issue reg 3 in cycle 0; ld_done 0xC3 in cycle 3 -> ld_busy=1 and busy_mask=1000 in cycles 1-3 -> cycle 4 writes reg 3 = 0xC3 -> cycle 5 shows busy_mask=0 and ld_busy=0.
- Ordering: ld_done (reg 1, 0x11) together with alu_valid (reg 1, 0x22) -> next cycle writes 0x11, the cycle after writes 0x22 -> final value 0x22, and busy bit 1 is held across both cycles.
- Fill to stall (DEPTH=4): every cycle, ld_issue+ld_done plus alu_valid -> count goes 1, 2, 3 -> stall=1 when count=3. Stop ALU and loads -> writes drain in order over 3 cycles -> stall drops at count=2.
- Violations: alu_valid during stall, or ld_done with ld_busy=0 -> no write occurs for that value, proto_err=1 and stays high.
- Reset mid-operation: 2 entries queued and a load outstanding; assert reset -> next cycle shows write_en=0, busy_mask=0, ld_busy=0, proto_err=0.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Result-producer and register-file write-port bundle for writeback_unit.
// The master side is the datapath (ALU, load path, decode), the slave side is the unit.
interface writeback_unit_if #(
  parameter int DATA_W = 8
);
  logic              alu_valid;
  logic [1:0]        alu_reg;
  logic [DATA_W-1:0] alu_value;
  logic              ld_issue;
  logic [1:0]        ld_reg;
  logic              ld_done;
  logic [DATA_W-1:0] ld_value;
  logic              write_en;
  logic [1:0]        write_reg;
  logic [DATA_W-1:0] write_value;
  logic [3:0]        busy_mask;
  logic              stall;
  logic              ld_busy;
  logic              proto_err;

  modport master (
    output alu_valid, alu_reg, alu_value, ld_issue, ld_reg, ld_done, ld_value,
    input  write_en, write_reg, write_value, busy_mask, stall, ld_busy, proto_err
  );

  modport slave (
    input  alu_valid, alu_reg, alu_value, ld_issue, ld_reg, ld_done, ld_value,
    output write_en, write_reg, write_value, busy_mask, stall, ld_busy, proto_err
  );
endinterface

// File: rtl/writeback_unit.sv
// In-order writeback queue merging ALU and load results onto one register-file write port,
// with a pending-write scoreboard for RAW stalls in decode.
module writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        fifo_reg_q [DEPTH];
  logic [DATA_W-1:0] fifo_val_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic          ld_busy_q, ld_busy_d;
  logic [1:0]    ld_reg_q, ld_reg_d;
  logic          proto_err_q, proto_err_d;

  logic              stall, deq;
  logic              alu_acc, done_acc, issue_acc;
  logic              enq0_en, enq1_en;
  logic [1:0]        enq0_reg;
  logic [DATA_W-1:0] enq0_val;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Stalling one entry early leaves room for an ld_done, which cannot be held off.
  assign stall = (count_q >= CW'(DEPTH - 1));
  assign deq   = (count_q != '0);

  always_comb begin
    alu_acc   = bus.alu_valid && !stall;
    done_acc  = bus.ld_done && ld_busy_q;
    issue_acc = bus.ld_issue && !stall && (!ld_busy_q || bus.ld_done);

    // The returning load is older than this cycle's ALU result, so it takes the first slot.
    enq0_en  = done_acc || alu_acc;
    enq1_en  = done_acc && alu_acc;
    enq0_reg = done_acc ? ld_reg_q : bus.alu_reg;
    enq0_val = done_acc ? bus.ld_value : bus.alu_value;

    wr_ptr_p1 = ptr_inc(wr_ptr_q);
    wr_ptr_d  = wr_ptr_q;
    if (enq1_en)      wr_ptr_d = ptr_inc(wr_ptr_p1);
    else if (enq0_en) wr_ptr_d = wr_ptr_p1;
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(enq0_en) + CW'(enq1_en) - CW'(deq);

    ld_busy_d = ld_busy_q;
    if (issue_acc)     ld_busy_d = 1'b1;
    else if (done_acc) ld_busy_d = 1'b0;
    ld_reg_d = issue_acc ? bus.ld_reg : ld_reg_q;

    proto_err_d = proto_err_q
                | (bus.alu_valid && stall)
                | (bus.ld_issue && !issue_acc)
                | (bus.ld_done && !ld_busy_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ld_busy_q   <= 1'b0;
      ld_reg_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ld_busy_q   <= ld_busy_d;
      ld_reg_q    <= ld_reg_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq0_en) begin
      fifo_reg_q[wr_ptr_q] <= enq0_reg;
      fifo_val_q[wr_ptr_q] <= enq0_val;
    end
    if (enq1_en) begin
      fifo_reg_q[wr_ptr_p1] <= bus.alu_reg;
      fifo_val_q[wr_ptr_p1] <= bus.alu_value;
    end
  end

  logic [3:0] entry_mask [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    int off;
    always_comb begin
      off = (gi + DEPTH - int'(rd_ptr_q)) % DEPTH;
      entry_mask[gi] = (off < int'(count_q)) ? (4'b0001 << fifo_reg_q[gi]) : 4'b0000;
    end
  end

  always_comb begin
    bus.busy_mask = ld_busy_q ? (4'b0001 << ld_reg_q) : 4'b0000;
    for (int i = 0; i < DEPTH; i++) bus.busy_mask = bus.busy_mask | entry_mask[i];
  end

  assign bus.write_en    = deq;
  assign bus.write_reg   = deq ? fifo_reg_q[rd_ptr_q] : 2'd0;
  assign bus.write_value = deq ? fifo_val_q[rd_ptr_q] : '0;
  assign bus.stall       = stall;
  assign bus.ld_busy     = ld_busy_q;
  assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: each task drives one scenario cycle by cycle and
// compares the full output vector {we, reg, value, busy_mask, stall, ld_busy, proto_err}.
module tb_writeback_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] rf [4];
  logic [17:0] obs;
  logic [17:0] exp_v;

  writeback_unit_if #(.DATA_W(8)) bus ();

  writeback_unit #(.DEPTH(4), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.write_en, bus.write_reg, bus.write_value, bus.busy_mask,
                bus.stall, bus.ld_busy, bus.proto_err};

  // Register-file model plus one line per write transaction.
  always @(posedge clk) begin
    if (!reset && bus.write_en) begin
      rf[bus.write_reg] <= bus.write_value;
      $display("write r%0d <= %h", bus.write_reg, bus.write_value);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_reg = 2'd0; bus.alu_value = 8'h00;
    bus.ld_issue = 1'b0;  bus.ld_reg = 2'd0;
    bus.ld_done = 1'b0;   bus.ld_value = 8'h00;
  endtask

  task automatic alu(input logic [1:0] r, input logic [7:0] v);
    bus.alu_valid = 1'b1; bus.alu_reg = r; bus.alu_value = v;
  endtask

  task automatic issue(input logic [1:0] r);
    bus.ld_issue = 1'b1; bus.ld_reg = r;
  endtask

  task automatic done(input logic [7:0] v);
    bus.ld_done = 1'b1; bus.ld_value = v;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_single_alu();
    alu(2'd2, 8'h5A); tick(); idle();
    exp_v = {1'b1, 2'd2, 8'h5A, 4'b0100, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alu_c1 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL alu_c2 got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_load();
    issue(2'd3); tick(); idle();
    for (int c = 1; c <= 3; c++) begin
      exp_v = {1'b0, 2'd0, 8'h00, 4'b1000, 3'b010};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL load_wait_c%0d got=%h exp=%h", c, obs, exp_v); end
      if (c < 3) tick();
    end
    done(8'hC3); tick(); idle();
    exp_v = {1'b1, 2'd3, 8'hC3, 4'b1000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL load_write got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL load_clear got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_ordering();
    issue(2'd1); tick(); idle();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0010, 3'b010};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL order_c1 got=%h exp=%h", obs, exp_v); end
    done(8'h11); alu(2'd1, 8'h22); tick(); idle();
    exp_v = {1'b1, 2'd1, 8'h11, 4'b0010, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL order_first got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b1, 2'd1, 8'h22, 4'b0010, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL order_second got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL order_empty got=%h exp=%h", obs, exp_v); end
    checks++; if (rf[1] !== 8'h22) begin errors++; $display("FAIL order_final_r1 got=%h exp=22", rf[1]); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        exp_v = {1'b1, 2'(k - 1), 8'(8'h40 + k - 1), 4'(4'b0001 << (k - 1)), 3'b000};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", k, obs, exp_v); end
      end
      idle();
      if (k < 4) alu(2'(k), 8'(8'h40 + k));
      tick();
    end
    idle();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_empty got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_fill_to_stall();
    issue(2'd0); alu(2'd1, 8'h01); tick(); idle();
    exp_v = {1'b1, 2'd1, 8'h01, 4'b0011, 3'b010};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL fill_cnt1 got=%h exp=%h", obs, exp_v); end
    issue(2'd3); done(8'hA0); alu(2'd2, 8'h02); tick(); idle();
    exp_v = {1'b1, 2'd0, 8'hA0, 4'b1101, 3'b010};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL fill_cnt2 got=%h exp=%h", obs, exp_v); end
    done(8'hB3); alu(2'd1, 8'h03); tick(); idle();
    exp_v = {1'b1, 2'd2, 8'h02, 4'b1110, 3'b100};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL fill_stall got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b1, 2'd3, 8'hB3, 4'b1010, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL drain_1 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b1, 2'd1, 8'h03, 4'b0010, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL drain_2 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL drain_empty got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_violations();
    done(8'h99); tick(); idle();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b001};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stray_done got=%h exp=%h", obs, exp_v); end
    issue(2'd0); alu(2'd1, 8'h11); tick(); idle();
    exp_v = {1'b1, 2'd1, 8'h11, 4'b0011, 3'b011};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL viol_c2 got=%h exp=%h", obs, exp_v); end
    issue(2'd0); done(8'h22); alu(2'd2, 8'h33); tick(); idle();
    exp_v = {1'b1, 2'd0, 8'h22, 4'b0101, 3'b011};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL viol_c3 got=%h exp=%h", obs, exp_v); end
    done(8'h44); alu(2'd3, 8'h55); tick(); idle();
    exp_v = {1'b1, 2'd2, 8'h33, 4'b1101, 3'b101};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL viol_stall got=%h exp=%h", obs, exp_v); end
    alu(2'd0, 8'h99); issue(2'd1); tick(); idle();
    exp_v = {1'b1, 2'd0, 8'h44, 4'b1001, 3'b001};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL viol_drop1 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b1, 2'd3, 8'h55, 4'b1000, 3'b001};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL viol_drop2 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b001};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL viol_sticky got=%h exp=%h", obs, exp_v); end
    checks++; if (rf[0] !== 8'h44) begin errors++; $display("FAIL viol_r0 got=%h exp=44", rf[0]); end
  endtask

  task automatic test_reset_mid();
    issue(2'd2); alu(2'd1, 8'h61); tick(); idle();
    exp_v = {1'b1, 2'd1, 8'h61, 4'b0110, 3'b011};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_c2 got=%h exp=%h", obs, exp_v); end
    issue(2'd0); done(8'h62); alu(2'd3, 8'h63); tick(); idle();
    exp_v = {1'b1, 2'd2, 8'h62, 4'b1101, 3'b011};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_c3 got=%h exp=%h", obs, exp_v); end
    reset = 1'b1; tick(); reset = 1'b0;
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs, exp_v); end
    done(8'h70); tick(); idle();
    exp_v = {1'b0, 2'd0, 8'h00, 4'b0000, 3'b001};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_late_done got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_alu();
    test_load();
    test_ordering();
    test_back_to_back();
    test_fill_to_stall();
    test_violations();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
